// File: rtl/gray_counter_multi.sv
// rtl/gray_counter_multi.sv - multi-channel binary/Gray up/down counter bank
//
// Ports:
//   clk_counter      counter clock, all state updates on its rising edge
//   reset_counter_n  asynchronous active-low reset
//   clear            per-channel synchronous clear to 0 (highest priority)
//   load             per-channel synchronous load of its load_value slice
//   load_value       load data, channel i uses [i*WIDTH +: WIDTH]
//   ce               per-channel count enable
//   dir              per-channel direction, 1 = up, 0 = down
//   saturate         per-channel limit mode, 1 = hold at limit, 0 = wrap
//   binary_out       registered binary count per channel
//   gray_out         registered Gray code of binary_out, same edge
//   tc_pulse         one-cycle pulse when a step starts at the terminal value
//   load_clamped     one-cycle pulse when a load exceeded MAX_VALUE
module gray_counter_multi #(
    parameter int WIDTH     = 8,
    parameter int NUM_CH    = 4,
    parameter int MAX_VALUE = 2**WIDTH - 1
) (
    input  logic                     clk_counter,
    input  logic                     reset_counter_n,
    input  logic [NUM_CH-1:0]        clear,
    input  logic [NUM_CH-1:0]        load,
    input  logic [NUM_CH*WIDTH-1:0]  load_value,
    input  logic [NUM_CH-1:0]        ce,
    input  logic [NUM_CH-1:0]        dir,
    input  logic [NUM_CH-1:0]        saturate,
    output logic [NUM_CH*WIDTH-1:0]  binary_out,
    output logic [NUM_CH*WIDTH-1:0]  gray_out,
    output logic [NUM_CH-1:0]        tc_pulse,
    output logic [NUM_CH-1:0]        load_clamped
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] bin_q, bin_d;
        logic [WIDTH-1:0] gray_q, gray_d;
        logic             tc_q, tc_d;
        logic             clamp_q, clamp_d;
        logic [WIDTH-1:0] ld_val;

        assign ld_val = load_value[i*WIDTH +: WIDTH];

        always_comb begin
            bin_d   = bin_q;
            tc_d    = 1'b0;
            clamp_d = 1'b0;
            if (clear[i]) begin
                bin_d = '0;
            end else if (load[i]) begin
                // Zero-extended compare so the test stays meaningful even
                // when MAX_VALUE is the full WIDTH-bit range.
                if ({1'b0, ld_val} > {1'b0, MAX_W}) begin
                    bin_d   = MAX_W;
                    clamp_d = 1'b1;
                end else begin
                    bin_d = ld_val;
                end
            end else if (ce[i]) begin
                if (dir[i]) begin
                    if (bin_q == MAX_W) begin
                        tc_d  = 1'b1;
                        bin_d = saturate[i] ? MAX_W : '0;
                    end else begin
                        bin_d = bin_q + ONE_W;
                    end
                end else begin
                    if (bin_q == '0) begin
                        tc_d  = 1'b1;
                        bin_d = saturate[i] ? '0 : MAX_W;
                    end else begin
                        bin_d = bin_q - ONE_W;
                    end
                end
            end
            // Gray derived from the next binary value so both land together.
            gray_d = bin_d ^ (bin_d >> 1);
        end

        always_ff @(posedge clk_counter or negedge reset_counter_n) begin
            if (!reset_counter_n) begin
                bin_q   <= '0;
                gray_q  <= '0;
                tc_q    <= 1'b0;
                clamp_q <= 1'b0;
            end else begin
                bin_q   <= bin_d;
                gray_q  <= gray_d;
                tc_q    <= tc_d;
                clamp_q <= clamp_d;
            end
        end

        assign binary_out[i*WIDTH +: WIDTH] = bin_q;
        assign gray_out[i*WIDTH +: WIDTH]   = gray_q;
        assign tc_pulse[i]                  = tc_q;
        assign load_clamped[i]              = clamp_q;
    end

endmodule

// File: tb/tb_gray_counter_multi.sv
// tb/tb_gray_counter_multi.sv - directed and randomized checks of gray_counter_multi
module tb_gray_counter_multi;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // DUT A: WIDTH=4, NUM_CH=4, MAX_VALUE=15 (power-of-two modulus)
    logic [3:0]  a_clr = '0, a_ld = '0, a_ce = '0, a_dir = '0, a_sat = '0;
    logic [15:0] a_lv = '0;
    logic [15:0] a_bin, a_gray;
    logic [3:0]  a_tc, a_cl;

    // DUT B: WIDTH=4, NUM_CH=1, MAX_VALUE=9
    logic        b_clr = 1'b0, b_ld = 1'b0, b_ce = 1'b0, b_dir = 1'b0, b_sat = 1'b0;
    logic [3:0]  b_lv = '0;
    logic [3:0]  b_bin, b_gray;
    logic        b_tc, b_cl;

    // DUT C: WIDTH=8, NUM_CH=4, MAX_VALUE=100
    logic [3:0]  c_clr = '0, c_ld = '0, c_ce = '0, c_dir = '0, c_sat = '0;
    logic [31:0] c_lv = '0;
    logic [31:0] c_bin, c_gray;
    logic [3:0]  c_tc, c_cl;

    gray_counter_multi #(.WIDTH(4), .NUM_CH(4), .MAX_VALUE(15)) dut_a (
        .clk_counter(clk), .reset_counter_n(rst_n),
        .clear(a_clr), .load(a_ld), .load_value(a_lv), .ce(a_ce), .dir(a_dir),
        .saturate(a_sat), .binary_out(a_bin), .gray_out(a_gray),
        .tc_pulse(a_tc), .load_clamped(a_cl)
    );

    gray_counter_multi #(.WIDTH(4), .NUM_CH(1), .MAX_VALUE(9)) dut_b (
        .clk_counter(clk), .reset_counter_n(rst_n),
        .clear(b_clr), .load(b_ld), .load_value(b_lv), .ce(b_ce), .dir(b_dir),
        .saturate(b_sat), .binary_out(b_bin), .gray_out(b_gray),
        .tc_pulse(b_tc), .load_clamped(b_cl)
    );

    gray_counter_multi #(.WIDTH(8), .NUM_CH(4), .MAX_VALUE(100)) dut_c (
        .clk_counter(clk), .reset_counter_n(rst_n),
        .clear(c_clr), .load(c_ld), .load_value(c_lv), .ce(c_ce), .dir(c_dir),
        .saturate(c_sat), .binary_out(c_bin), .gray_out(c_gray),
        .tc_pulse(c_tc), .load_clamped(c_cl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven at the falling edge; outputs are sampled at the next one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] g4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] g8(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [3:0] exp_b, prev_b, prev_g;
    logic [3:0] m_bin [4];
    logic       m_tc  [4];
    int         r;

    initial begin
        // ---------------- reset state ----------------
        #2;
        check("rst_a_bin", a_bin, 16'h0);
        check("rst_a_gray", a_gray, 16'h0);
        check("rst_a_pulses", {a_tc, a_cl}, 8'h0);
        check("rst_b_all", {b_bin, b_gray, b_tc, b_cl}, 10'h0);
        check("rst_c_all", {c_bin, c_gray}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold_ce0_%0d", k), {a_bin, a_gray, a_tc, a_cl}, 40'h0);
        end

        // ---------------- async reset mid-count ----------------
        a_ce[0] = 1'b1; a_dir[0] = 1'b1;
        step(); step(); step();
        check("precount_a0", a_bin[3:0], 4'd3);
        rst_n = 1'b0;
        #1;
        check("async_rst_bin", a_bin[3:0], 4'd0);
        check("async_rst_gray", a_gray[3:0], 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("first_after_release", a_bin[3:0], 4'd1);
        a_ce[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("re_reset_a0", a_bin[3:0], 4'd0);

        // ---------------- up wrap, MAX=15, 17 steps ----------------
        a_ce[0] = 1'b1; a_dir[0] = 1'b1; a_sat[0] = 1'b0;
        prev_b = 4'd0; prev_g = 4'd0;
        for (int k = 0; k < 17; k++) begin
            step();
            exp_b = (prev_b == 4'd15) ? 4'd0 : prev_b + 4'd1;
            check($sformatf("upwrap_bin_%0d", k), a_bin[3:0], exp_b);
            check($sformatf("upwrap_gray_%0d", k), a_gray[3:0], g4(exp_b));
            check($sformatf("upwrap_1bit_%0d", k), $countones(a_gray[3:0] ^ prev_g), 1);
            check($sformatf("upwrap_tc_%0d", k), a_tc[0], prev_b == 4'd15);
            prev_b = a_bin[3:0];
            prev_g = a_gray[3:0];
        end
        a_ce[0] = 1'b0;
        step();
        check("upwrap_hold", {a_bin[3:0], a_tc[0]}, {4'd1, 1'b0});

        // ---------------- saturate down, MAX=9 ----------------
        b_ld = 1'b1; b_lv = 4'd2;
        step();
        check("satdn_load2", b_bin, 4'd2);
        b_ld = 1'b0; b_ce = 1'b1; b_dir = 1'b0; b_sat = 1'b1;
        step(); check("satdn_1", {b_bin, b_tc}, {4'd1, 1'b0});
        step(); check("satdn_2", {b_bin, b_tc}, {4'd0, 1'b0});
        step(); check("satdn_3", {b_bin, b_tc}, {4'd0, 1'b1});
        step(); check("satdn_4", {b_bin, b_tc}, {4'd0, 1'b1});
        step(); check("satdn_5", {b_bin, b_tc, b_gray}, {4'd0, 1'b1, 4'd0});

        // ---------------- non-power-of-two wrap, MAX=9 ----------------
        b_ce = 1'b0; b_ld = 1'b1; b_lv = 4'd9;
        step(); check("np2_load9", {b_bin, b_gray, b_cl}, {4'd9, 4'hD, 1'b0});
        b_ld = 1'b0; b_ce = 1'b1; b_dir = 1'b1; b_sat = 1'b0;
        step(); check("np2_up_wrap", {b_bin, b_gray, b_tc}, {4'd0, 4'd0, 1'b1});
        b_dir = 1'b0;
        step(); check("np2_dn_wrap", {b_bin, b_gray, b_tc}, {4'd9, 4'hD, 1'b1});
        b_ce = 1'b0;
        step(); check("np2_hold", {b_bin, b_tc}, {4'd9, 1'b0});
        b_sat = 1'b1; b_dir = 1'b1; b_ce = 1'b1;
        step(); check("np2_sat_up", {b_bin, b_tc}, {4'd9, 1'b1});
        b_ce = 1'b0;

        // ---------------- load clamp and priority, MAX=100 ----------------
        c_ld = 4'b1110;
        c_lv = {8'd100, 8'd77, 8'd30, 8'd0};
        step();
        check("lc_setup_bin", c_bin, {8'd100, 8'd77, 8'd30, 8'd0});
        check("lc_setup_noclamp", c_cl, 4'b0000);
        c_ld  = 4'b0011;
        c_clr = 4'b0010;
        c_ce  = 4'b0010;
        c_lv  = {8'd0, 8'd0, 8'd50, 8'd200};
        step();
        check("lc_ch0_clamped", c_bin[7:0], 8'd100);
        check("lc_ch0_gray", c_gray[7:0], g8(8'd100));
        check("lc_clamp_pulse", c_cl, 4'b0001);
        check("lc_tc", c_tc, 4'b0000);
        check("lc_ch1_cleared", {c_bin[15:8], c_gray[15:8]}, 16'h0);
        check("lc_other_ch", c_bin[31:16], {8'd100, 8'd77});
        c_ld = '0; c_clr = '0; c_ce = 4'b1000; c_dir = 4'b1000; c_sat = '0;
        step();
        check("lc_clamp_oneshot", c_cl, 4'b0000);
        check("lc_ch3_wrap", {c_bin[31:24], c_tc}, {8'd0, 4'b1000});
        check("lc_rest_held", c_bin[23:0], {8'd77, 8'd0, 8'd100});
        c_ce = '0;

        // ---------------- random channel independence ----------------
        a_clr = '0; a_ld = '0; a_ce = '0;
        step();
        for (int ch = 0; ch < 4; ch++) begin
            m_bin[ch] = a_bin[ch*4 +: 4];
            m_tc[ch]  = 1'b0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int ch = 0; ch < 4; ch++) begin
                r = $urandom_range(0, 99);
                a_clr[ch] = (r < 2 + ch);
                a_ld[ch]  = (r >= 50 && r < 55 + ch);
                a_ce[ch]  = ($urandom_range(0, ch + 1) != 0);
                a_dir[ch] = ($urandom_range(0, 3) < ch + 1) ^ (ch == 3);
                a_sat[ch] = ($urandom_range(0, 1) == 1);
                a_lv[ch*4 +: 4] = 4'($urandom_range(0, 15));
                m_tc[ch] = 1'b0;
                if (a_clr[ch]) begin
                    m_bin[ch] = 4'd0;
                end else if (a_ld[ch]) begin
                    m_bin[ch] = a_lv[ch*4 +: 4];
                end else if (a_ce[ch] && a_dir[ch]) begin
                    m_tc[ch]  = (m_bin[ch] == 4'd15);
                    m_bin[ch] = m_tc[ch] ? (a_sat[ch] ? 4'd15 : 4'd0) : m_bin[ch] + 4'd1;
                end else if (a_ce[ch]) begin
                    m_tc[ch]  = (m_bin[ch] == 4'd0);
                    m_bin[ch] = m_tc[ch] ? (a_sat[ch] ? 4'd0 : 4'd15) : m_bin[ch] - 4'd1;
                end
            end
            step();
            for (int ch = 0; ch < 4; ch++) begin
                check($sformatf("rand_c%0d_cyc%0d", ch, cyc),
                      {a_bin[ch*4 +: 4], a_gray[ch*4 +: 4], a_tc[ch], a_cl[ch]},
                      {m_bin[ch], g4(m_bin[ch]), m_tc[ch], 1'b0});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_counter_multi.md
# gray_counter_multi

Multi-channel, parametrised binary/Gray counter bank for a single clock domain. It is the successor to the single-channel gray counter. Each channel counts up or down over a programmable modulus, wraps or saturates at the range limits, and can be loaded or cleared. Each channel registers its binary value and the matching Gray code on the same edge, and emits a terminal-count pulse. Downstream CDC synchronisers consume the Gray outputs. Pointer/occupancy logic consumes the binary outputs.

## Interface
- WIDTH, 8, counter width in bits per channel (≥2)
- NUM_CH, 4, number of independent channels (≥1)
- MAX_VALUE, 2**WIDTH-1, upper count limit; channel range is 0..MAX_VALUE (must be ≤ 2**WIDTH-1)

Ports:
- clk_counter  in  1  counter clock; all state updates on rising edge
- reset_counter_n  in  1  asynchronous, active-low reset; deassertion assumed synchronous to clk_counter externally
- clear  in  NUM_CH  per-channel synchronous clear to 0
- load  in  NUM_CH  per-channel synchronous load of load_value slice
- load_value  in  NUM_CH*WIDTH  load data; channel i uses bits [i*WIDTH +: WIDTH]
- ce  in  NUM_CH  per-channel count enable
- dir  in  NUM_CH  1 = count up, 0 = count down
- saturate  in  NUM_CH  1 = hold at limit, 0 = wrap modulo MAX_VALUE+1
- binary_out  out  NUM_CH*WIDTH  registered binary count, slice per channel
- gray_out  out  NUM_CH*WIDTH  registered Gray code of binary_out, same edge
- tc_pulse  out  NUM_CH  one-cycle terminal-count pulse
- load_clamped  out  NUM_CH  one-cycle pulse: load_value exceeded MAX_VALUE and was clamped

## Operation
- Channels are fully independent. There is no cross-channel interaction.
- Per-channel priority each cycle: clear > load > ce > hold.
- clear: binary ← 0, gray ← 0, tc_pulse ← 0, load_clamped ← 0.
- load: binary ← min(load_value, MAX_VALUE).
  - load_clamped ← 1 iff load_value > MAX_VALUE.
  - tc_pulse ← 0.
  - ce is ignored that cycle.
- ce with dir=1:
  - Value < MAX_VALUE → +1.
  - Value = MAX_VALUE → 0 if saturate=0, else hold MAX_VALUE.
- ce with dir=0:
  - Value > 0 → −1.
  - Value = 0 → MAX_VALUE if saturate=0, else hold 0.
- tc_pulse ← 1 for exactly one cycle when a ce step starts at the terminal value for its direction (MAX_VALUE for up, 0 for down), in either wrap or saturate mode.
  - In saturate mode it re-pulses on every further ce cycle held at the limit.
- Gray encoding: gray = binary ^ (binary >> 1), computed from the next binary value and registered with it. gray_out is never one cycle behind binary_out.
- Arithmetic is performed in WIDTH bits. No intermediate value may exceed WIDTH bits.
  - The wrap is explicit at MAX_VALUE, not natural overflow.
- Single-bit Gray transitions are guaranteed for ±1 steps.
  - For wrap, this holds only when MAX_VALUE+1 is a power of two. Other moduli are legal, but the wrap step may change multiple bits.
  - Load and clear may change any number of bits.
- A ce of 0 holds all state. tc_pulse and load_clamped are forced to 0.

## Timing
- Latency: 1 clk_counter cycle from control inputs to binary_out/gray_out/tc_pulse/load_clamped. All outputs are registered, with no combinational input-to-output path.
- Reset: reset_counter_n low immediately forces binary_out=0, gray_out=0, tc_pulse=0, load_clamped=0 for all channels, asynchronously and independent of the clock.
- Reset asserted mid-count discards the step in progress. The first update after release uses the inputs sampled on the first rising edge with reset_counter_n high.
- Direction may change every cycle. A change of dir with ce=1 takes effect on that same edge.
- Simultaneous clear+load+ce on one channel resolves to clear. Other channels are unaffected.
- Throughput: one step per channel per cycle.

## Test plan
- Reset/hold: assert reset_counter_n=0 mid-count → all outputs 0 immediately. Release with ce=0 for 5 cycles → outputs stay 0.
- Up wrap, WIDTH=4, MAX_VALUE=15, ch0 ce=1 dir=1 saturate=0 for 17 cycles:
  - binary_out 0,1,…,15,0,1.
  - gray_out matches b^(b>>1) every cycle, with exactly one bit changing per step including 15→0.
  - tc_pulse high only in the cycle after the 15→0 step.
- Saturate down, MAX_VALUE=9: load 2, then dir=0 saturate=1 ce=1 for 5 cycles → binary 1,0,0,0,0. tc_pulse high on the last 3 cycles.
- Non-power-of-two wrap, MAX_VALUE=9: from 9, one up step → 0 with tc_pulse. From 0, one down step → 9 with tc_pulse.
- Load clamp and priority:
  - load_value=200 with MAX_VALUE=100 → binary_out=100, load_clamped pulses 1 cycle.
  - Same cycle clear=1 on ch1 with load=1, ce=1 → ch1=0, no pulses.
  - Other channels unaffected.
- Channel independence, NUM_CH=4: drive each channel with a distinct random ce/dir/load/saturate pattern for 1000 cycles → every channel matches a per-channel reference model cycle-exactly.
